// File: rtl/sd_arbiter.sv
// Round-robin two-port arbiter and single-transaction sequencer for the sdcard byte port.
// Latency: 4 cycles minimum (hit path), ready-rise + 1 on a miss; requests are held levels, grants only while sd_ready=1.
module sd_arbiter #(
  parameter logic [23:0] TIMEOUT = 24'd10_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_addr,
  input  logic [7:0]  m0_wdata,
  output logic [7:0]  m0_rdata,
  output logic        m0_done,
  output logic        m0_err,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_addr,
  input  logic [7:0]  m1_wdata,
  output logic [7:0]  m1_rdata,
  output logic        m1_done,
  output logic        m1_err,
  output logic [31:0] sd_addr,
  output logic [7:0]  sd_write_data,
  output logic        sd_read,
  output logic        sd_write,
  input  logic [7:0]  sd_read_data,
  input  logic        sd_ready
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, DONE} state_t;

  state_t      state;
  logic        last;
  logic        gnt;
  logic        op_wr;
  logic [1:0]  win_cnt;
  logic [23:0] to_cnt;

  logic m0_pend, m1_pend, pick, pick_wr;

  assign m0_pend = m0_read | m0_write;
  assign m1_pend = m1_read | m1_write;
  // Contention goes to the port not served last; otherwise the lone requester wins.
  assign pick    = (m0_pend && m1_pend) ? ~last : m1_pend;
  assign pick_wr = pick ? m1_write : m0_write;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      last          <= 1'b1;
      gnt           <= 1'b0;
      op_wr         <= 1'b0;
      win_cnt       <= 2'd0;
      to_cnt        <= 24'd0;
      sd_addr       <= 32'd0;
      sd_write_data <= 8'd0;
      sd_read       <= 1'b0;
      sd_write      <= 1'b0;
      m0_rdata      <= 8'd0;
      m1_rdata      <= 8'd0;
      m0_done       <= 1'b0;
      m1_done       <= 1'b0;
      m0_err        <= 1'b0;
      m1_err        <= 1'b0;
    end else begin
      sd_read  <= 1'b0;
      sd_write <= 1'b0;
      m0_done  <= 1'b0;
      m1_done  <= 1'b0;
      m0_err   <= 1'b0;
      m1_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (sd_ready && (m0_pend || m1_pend)) begin
            gnt           <= pick;
            last          <= pick;
            op_wr         <= pick_wr;
            sd_addr       <= pick ? m1_addr : m0_addr;
            sd_write_data <= pick ? m1_wdata : m0_wdata;
            sd_write      <= pick_wr;
            sd_read       <= ~pick_wr;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          win_cnt <= 2'd0;
          state   <= WAIT_LOW;
        end
        WAIT_LOW: begin
          if (!sd_ready) begin
            to_cnt <= 24'd0;
            state  <= WAIT_HIGH;
          end else if (win_cnt == 2'd1) begin
            // Card never went busy: the byte is already on sd_read_data.
            if (!op_wr) begin
              if (gnt) m1_rdata <= sd_read_data;
              else     m0_rdata <= sd_read_data;
            end
            m0_done <= ~gnt;
            m1_done <= gnt;
            state   <= DONE;
          end else begin
            win_cnt <= win_cnt + 2'd1;
          end
        end
        WAIT_HIGH: begin
          if (sd_ready) begin
            if (!op_wr) begin
              if (gnt) m1_rdata <= sd_read_data;
              else     m0_rdata <= sd_read_data;
            end
            m0_done <= ~gnt;
            m1_done <= gnt;
            state   <= DONE;
          end else if (to_cnt >= TIMEOUT - 24'd1) begin
            m0_done <= ~gnt;
            m1_done <= gnt;
            m0_err  <= ~gnt;
            m1_err  <= gnt;
            state   <= DONE;
          end else if (to_cnt != 24'hFF_FFFF) begin
            to_cnt <= to_cnt + 24'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_arbiter.sv
// Scoreboard bench for sd_arbiter: a default-timeout instance and a TIMEOUT=16 instance share stimulus and a simple sdcard model.
`timescale 1ns/1ps
module tb_sd_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [31:0] m0_addr = '0, m1_addr = '0;
  logic [7:0]  m0_wdata = '0, m1_wdata = '0;
  logic [7:0]  sd_read_data = 8'hEE;
  logic        sd_ready = 1'b1;

  logic [7:0]  a_m0_rdata, a_m1_rdata, a_sd_write_data, b_m0_rdata, b_m1_rdata, b_sd_write_data;
  logic        a_m0_done, a_m1_done, a_m0_err, a_m1_err, a_sd_read, a_sd_write;
  logic        b_m0_done, b_m1_done, b_m0_err, b_m1_err, b_sd_read, b_sd_write;
  logic [31:0] a_sd_addr, b_sd_addr;

  sd_arbiter dut_a (
    .clk(clk), .rst_n(rst_n),
    .m0_read(m0_read), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(a_m0_rdata), .m0_done(a_m0_done), .m0_err(a_m0_err),
    .m1_read(m1_read), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(a_m1_rdata), .m1_done(a_m1_done), .m1_err(a_m1_err),
    .sd_addr(a_sd_addr), .sd_write_data(a_sd_write_data), .sd_read(a_sd_read), .sd_write(a_sd_write),
    .sd_read_data(sd_read_data), .sd_ready(sd_ready)
  );

  sd_arbiter #(.TIMEOUT(24'd16)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .m0_read(m0_read), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(b_m0_rdata), .m0_done(b_m0_done), .m0_err(b_m0_err),
    .m1_read(m1_read), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(b_m1_rdata), .m1_done(b_m1_done), .m1_err(b_m1_err),
    .sd_addr(b_sd_addr), .sd_write_data(b_sd_write_data), .sd_read(b_sd_read), .sd_write(b_sd_write),
    .sd_read_data(sd_read_data), .sd_ready(sd_ready)
  );

  // Observed instance: 0 = default timeout, 1 = TIMEOUT=16.
  logic mon_sel = 1'b0;
  logic [7:0]  o_r0, o_r1, o_wd;
  logic        o_d0, o_d1, o_e0, o_e1, o_rd, o_wr;
  logic [31:0] o_addr;
  assign o_r0   = mon_sel ? b_m0_rdata : a_m0_rdata;
  assign o_r1   = mon_sel ? b_m1_rdata : a_m1_rdata;
  assign o_d0   = mon_sel ? b_m0_done  : a_m0_done;
  assign o_d1   = mon_sel ? b_m1_done  : a_m1_done;
  assign o_e0   = mon_sel ? b_m0_err   : a_m0_err;
  assign o_e1   = mon_sel ? b_m1_err   : a_m1_err;
  assign o_rd   = mon_sel ? b_sd_read  : a_sd_read;
  assign o_wr   = mon_sel ? b_sd_write : a_sd_write;
  assign o_addr = mon_sel ? b_sd_addr  : a_sd_addr;
  assign o_wd   = mon_sel ? b_sd_write_data : a_sd_write_data;

  logic [61:0] a_outs, b_outs;
  assign a_outs = {a_sd_addr, a_sd_write_data, a_sd_read, a_sd_write, a_m0_rdata, a_m1_rdata,
                   a_m0_done, a_m1_done, a_m0_err, a_m1_err};
  assign b_outs = {b_sd_addr, b_sd_write_data, b_sd_read, b_sd_write, b_m0_rdata, b_m1_rdata,
                   b_m0_done, b_m1_done, b_m0_err, b_m1_err};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // sdcard model: HIT keeps ready high and presents the byte only in WAIT_LOW's second cycle,
  // MISS drops ready for busy_len cycles, HANG holds ready low until rel is raised.
  localparam int HIT = 0, MISS = 1, HANG = 2;
  int          mode = HIT, busy_len = 1, busy = 0, hph = 0;
  logic        rel = 1'b0, post = 1'b0;
  logic [7:0]  hit_data = '0, miss_data = '0;

  always @(posedge clk) begin
    if (o_rd | o_wr) begin
      if (mode == HIT) begin
        hph <= 1;
        sd_read_data <= 8'h11;
      end else begin
        sd_ready <= 1'b0;
        busy <= busy_len - 1;
        sd_read_data <= 8'hEE;
      end
    end else if (hph == 1) begin
      sd_read_data <= hit_data;
      hph <= 2;
    end else if (hph == 2) begin
      sd_read_data <= 8'hEE;
      hph <= 0;
    end else if (!sd_ready) begin
      if (rel) sd_ready <= 1'b1;
      else if (mode == MISS) begin
        if (busy != 0) busy <= busy - 1;
        else begin
          sd_ready <= 1'b1;
          sd_read_data <= miss_data;
          post <= 1'b1;
        end
      end
    end else if (post) begin
      sd_read_data <= 8'hEE;
      post <= 1'b0;
    end
  end

  typedef struct { logic wr; logic [31:0] addr; logic [7:0] wd; } stb_t;
  typedef struct { logic port; logic err; logic chk_rd; logic [7:0] rd; int cyc; } dn_t;
  stb_t sq[$];
  dn_t  dq[$];
  int total = 0, bad = 0, ndone = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push_stb(input logic wr, input logic [31:0] addr, input logic [7:0] wd);
    stb_t s;
    s.wr = wr; s.addr = addr; s.wd = wd;
    sq.push_back(s);
  endtask

  task automatic push_dn(input logic port, input logic err, input logic chk_rd, input logic [7:0] rd, input int c);
    dn_t d;
    d.port = port; d.err = err; d.chk_rd = chk_rd; d.rd = rd; d.cyc = c;
    dq.push_back(d);
  endtask

  task automatic mon_step();
    stb_t s;
    dn_t  d;
    logic ok;
    if (o_rd | o_wr) begin
      total++;
      if (sq.size() == 0) begin
        bad++;
        $display("FAIL strobe: unexpected rd=%0b wr=%0b addr=%h cyc=%0d", o_rd, o_wr, o_addr, cyc);
      end else begin
        s = sq.pop_front();
        if (o_wr !== s.wr || o_rd !== !s.wr || o_addr !== s.addr || (s.wr && o_wd !== s.wd)) begin
          bad++;
          $display("FAIL strobe: got rd=%0b wr=%0b addr=%h wd=%h, want wr=%0b addr=%h wd=%h",
                   o_rd, o_wr, o_addr, o_wd, s.wr, s.addr, s.wd);
        end
      end
    end
    if (o_d0 | o_d1) begin
      ndone++;
      total++;
      if (dq.size() == 0) begin
        bad++;
        $display("FAIL done: unexpected d0=%0b d1=%0b cyc=%0d", o_d0, o_d1, cyc);
      end else begin
        d = dq.pop_front();
        ok = (o_d0 ^ o_d1) && (o_d1 == d.port)
             && ((d.port ? o_e1 : o_e0) === d.err) && ((d.port ? o_e0 : o_e1) === 1'b0)
             && (!d.chk_rd || (d.port ? o_r1 : o_r0) === d.rd)
             && (d.cyc < 0 || cyc == d.cyc);
        if (!ok) begin
          bad++;
          $display("FAIL done: got d0=%0b d1=%0b e0=%0b e1=%0b r0=%h r1=%h cyc=%0d, want port=%0d err=%0b rd=%h cyc=%0d",
                   o_d0, o_d1, o_e0, o_e1, o_r0, o_r1, cyc, d.port, d.err, d.rd, d.cyc);
        end
      end
    end else if (o_e0 | o_e1) begin
      total++;
      bad++;
      $display("FAIL err_alone: got e0=%0b e1=%0b without done, want none", o_e0, o_e1);
    end
  endtask

  task automatic wait_done(input int target, input int limit);
    int n;
    n = 0;
    while (ndone < target && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    if (ndone < target) begin
      total++;
      bad++;
      $display("FAIL wait_done: got %0d dones, want %0d", ndone, target);
    end
  endtask

  task automatic do_reset();
    mode = HIT;
    rel = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rel = 1'b0;
  endtask

  initial begin
    int base;
    fork
      forever begin
        @(negedge clk);
        mon_step();
      end
    join_none

    do_reset();
    @(negedge clk);
    chk("reset_outs", {2'b0, a_outs}, 64'd0);

    // Miss read on port 0: ready low for 50 cycles, done one cycle after it rises.
    @(posedge clk); #1;
    mode = MISS; busy_len = 50; miss_data = 8'hA5;
    m0_addr = 32'h0000_0200; m0_wdata = 8'h00;
    push_stb(1'b0, 32'h200, 8'h00);
    push_dn(1'b0, 1'b0, 1'b1, 8'hA5, cyc + 53);
    base = ndone;
    m0_read = 1'b1;
    wait_done(base + 1, 200);
    m0_read = 1'b0;

    // Both pending after reset: port 0 first, then port 1's write five cycles later.
    do_reset();
    mode = HIT; hit_data = 8'hC3;
    m0_addr = 32'h10; m1_addr = 32'h20; m1_wdata = 8'h3C;
    push_stb(1'b0, 32'h10, 8'h00);
    push_dn(1'b0, 1'b0, 1'b1, 8'hC3, cyc + 4);
    push_stb(1'b1, 32'h20, 8'h3C);
    push_dn(1'b1, 1'b0, 1'b0, 8'h00, cyc + 9);
    base = ndone;
    m0_read = 1'b1; m1_write = 1'b1;
    wait_done(base + 1, 50);
    m0_read = 1'b0;
    wait_done(base + 2, 50);
    m1_write = 1'b0;

    // Continuous contention: strict alternation starting at port 0.
    @(posedge clk); #1;
    hit_data = 8'h6B;
    m0_addr = 32'h100; m1_addr = 32'h200; m1_wdata = 8'h77;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) begin
        push_stb(1'b0, 32'h100, 8'h00);
        push_dn(1'b0, 1'b0, 1'b1, 8'h6B, cyc + 4 + 5 * k);
      end else begin
        push_stb(1'b1, 32'h200, 8'h77);
        push_dn(1'b1, 1'b0, 1'b0, 8'h00, cyc + 4 + 5 * k);
      end
    end
    base = ndone;
    m0_read = 1'b1; m1_write = 1'b1;
    wait_done(base + 6, 100);
    m0_read = 1'b0; m1_write = 1'b0;

    // Hit-path read on port 1: minimum latency, byte from the cycle before DONE.
    @(posedge clk); #1;
    hit_data = 8'h2D; m1_addr = 32'h300;
    push_stb(1'b0, 32'h300, 8'h00);
    push_dn(1'b1, 1'b0, 1'b1, 8'h2D, cyc + 4);
    base = ndone;
    m1_read = 1'b1;
    wait_done(base + 1, 50);
    m1_read = 1'b0;

    // Timeout instance: establish m1_rdata, then let the card hang.
    mon_sel = 1'b1;
    do_reset();
    hit_data = 8'h5A; m1_addr = 32'h40;
    push_stb(1'b0, 32'h40, 8'h00);
    push_dn(1'b1, 1'b0, 1'b1, 8'h5A, cyc + 4);
    base = ndone;
    m1_read = 1'b1;
    wait_done(base + 1, 50);
    m1_read = 1'b0;

    @(posedge clk); #1;
    mode = HANG; m1_addr = 32'h44;
    push_stb(1'b0, 32'h44, 8'h00);
    push_dn(1'b1, 1'b1, 1'b1, 8'h5A, cyc + 19);
    base = ndone;
    m1_read = 1'b1;
    wait_done(base + 1, 60);
    m1_read = 1'b0;

    // Arbiter must be idle again: once ready returns, a hit read completes with minimum latency.
    mode = HIT; rel = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rel = 1'b0;
    hit_data = 8'h99; m0_addr = 32'h48;
    push_stb(1'b0, 32'h48, 8'h00);
    push_dn(1'b0, 1'b0, 1'b1, 8'h99, cyc + 4);
    base = ndone;
    m0_read = 1'b1;
    wait_done(base + 1, 50);
    m0_read = 1'b0;

    // Reset during WAIT_HIGH: outputs clear, no done, no grant until ready returns.
    @(posedge clk); #1;
    mode = HANG; m1_addr = 32'h80; m1_wdata = 8'h99;
    push_stb(1'b1, 32'h80, 8'h99);
    m1_write = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_outs", {2'b0, b_outs}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    push_stb(1'b1, 32'h80, 8'h99);
    push_dn(1'b1, 1'b0, 1'b0, 8'h00, -1);
    base = ndone;
    mode = HIT; rel = 1'b1;
    wait_done(base + 1, 50);
    m1_write = 1'b0; rel = 1'b0;

    repeat (4) @(posedge clk);
    #1;
    chk("queues_empty", 64'(sq.size() + dq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
